snoop_mem_responder: RTL and testbench

- Memory-side responder on the shared MSI snooping bus; the other end of the cache controllers' bus requests.
- Caches issue read miss, write miss, invalidate and write-back transactions to this block.
- For miss and invalidate transactions it broadcasts the transaction to all snoopers.
- An owner holding the line in Modified may abort the memory access and supply the data. Otherwise this block services the request from its internal memory after a fixed latency, and returns a one-cycle response.

---
 rtl/snoop_mem_responder.sv | 162 ++++++++++++++++
 tb/tb_snoop_mem_responder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_mem_responder.sv
// Memory-side responder for the shared MSI snooping bus: broadcasts misses/invalidates,
// honours owner aborts, and answers from local memory. Optional: SNOOP_MEM_RESPONDER_STATS_EN.
module snoop_mem_responder #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_cmd,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              bus_read_miss,
  output logic              bus_write_miss,
  output logic              bus_invalidate,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              snoop_abort,
  input  logic [DATA_W-1:0] snoop_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data
`ifdef SNOOP_MEM_RESPONDER_STATS_EN
  ,
  output logic [15:0]       stat_txn,
  output logic [15:0]       stat_abort
`endif
);

  localparam logic [1:0] CMD_RD  = 2'b00;
  localparam logic [1:0] CMD_WR  = 2'b01;
  localparam logic [1:0] CMD_INV = 2'b10;
  localparam logic [1:0] CMD_WB  = 2'b11;
  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

  typedef enum logic [2:0] {IDLE, BCAST, MEM_WAIT, WB, RESP} state_t;

  state_t              state;
  logic [1:0]          cmd_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [3:0]          lat_cnt;
  logic [DATA_W-1:0]   mem [2**ADDR_W];

  logic                is_miss;
  logic                abort_hit;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_wd;

  assign is_miss   = (cmd_q == CMD_RD) || (cmd_q == CMD_WR);
  assign abort_hit = (state == BCAST) && is_miss && snoop_abort;

  // Memory is written either by an owner's aborted miss or by a write-back.
  always_comb begin
    mem_we = abort_hit || (state == WB);
    mem_wd = (state == WB) ? wdata_q : snoop_wdata;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= mem_wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      req_ready      <= 1'b1;
      bus_read_miss  <= 1'b0;
      bus_write_miss <= 1'b0;
      bus_invalidate <= 1'b0;
      bus_addr       <= '0;
      resp_valid     <= 1'b0;
      resp_data      <= '0;
      lat_cnt        <= '0;
      cmd_q          <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cmd_q     <= req_cmd;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (req_cmd == CMD_WB) begin
              state <= WB;
            end else begin
              state          <= BCAST;
              bus_read_miss  <= (req_cmd == CMD_RD);
              bus_write_miss <= (req_cmd == CMD_WR);
              bus_invalidate <= (req_cmd == CMD_INV);
              bus_addr       <= req_addr;
            end
          end
        end
        // Snoopers answer combinationally, so the abort is decided on this edge.
        BCAST: begin
          bus_read_miss  <= 1'b0;
          bus_write_miss <= 1'b0;
          bus_invalidate <= 1'b0;
          bus_addr       <= '0;
          if (cmd_q == CMD_INV) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_data  <= '0;
          end else if (snoop_abort) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_data  <= snoop_wdata;
          end else if (MEM_LAT == 0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_data  <= mem[addr_q];
          end else begin
            state   <= MEM_WAIT;
            lat_cnt <= LAT_INIT;
          end
        end
        MEM_WAIT: begin
          if (lat_cnt == 4'd1) begin
            state      <= RESP;
            lat_cnt    <= '0;
            resp_valid <= 1'b1;
            resp_data  <= mem[addr_q];
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        WB: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_data  <= '0;
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_data  <= '0;
          req_ready  <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef SNOOP_MEM_RESPONDER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_txn   <= '0;
      stat_abort <= '0;
    end else begin
      if ((state == RESP) && (stat_txn != 16'hFFFF)) stat_txn <= stat_txn + 16'd1;
      if (abort_hit && (stat_abort != 16'hFFFF)) stat_abort <= stat_abort + 16'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_snoop_mem_responder.sv
// Self-checking bench for snoop_mem_responder: directed table, hold/reset sequences,
// random transactions against a memory-array reference model, plus a MEM_LAT=0 instance.
module tb_snoop_mem_responder;

  localparam int MEM_LAT = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready, req_ready0;
  logic [1:0] req_cmd;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       bus_read_miss, bus_write_miss, bus_invalidate;
  logic       bus_read_miss0, bus_write_miss0, bus_invalidate0;
  logic [3:0] bus_addr, bus_addr0;
  logic       snoop_abort;
  logic [7:0] snoop_wdata;
  logic       resp_valid, resp_valid0;
  logic [7:0] resp_data, resp_data0;
`ifdef SNOOP_MEM_RESPONDER_STATS_EN
  logic [15:0] stat_txn, stat_abort, stat_txn0, stat_abort0;
`endif

  always #5 clk = ~clk;

  snoop_mem_responder #(.ADDR_W(4), .DATA_W(8), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata),
    .bus_read_miss(bus_read_miss), .bus_write_miss(bus_write_miss),
    .bus_invalidate(bus_invalidate), .bus_addr(bus_addr),
    .snoop_abort(snoop_abort), .snoop_wdata(snoop_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data)
`ifdef SNOOP_MEM_RESPONDER_STATS_EN
    , .stat_txn(stat_txn), .stat_abort(stat_abort)
`endif
  );

  snoop_mem_responder #(.ADDR_W(4), .DATA_W(8), .MEM_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready0),
    .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata),
    .bus_read_miss(bus_read_miss0), .bus_write_miss(bus_write_miss0),
    .bus_invalidate(bus_invalidate0), .bus_addr(bus_addr0),
    .snoop_abort(snoop_abort), .snoop_wdata(snoop_wdata),
    .resp_valid(resp_valid0), .resp_data(resp_data0)
`ifdef SNOOP_MEM_RESPONDER_STATS_EN
    , .stat_txn(stat_txn0), .stat_abort(stat_abort0)
`endif
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] model_mem [16];

  int         r_wait, r_lat, r_lat0, n_rd, n_wr, n_inv, r_addr_bad, r_ready_low;
  logic [7:0] r_data, r_data0;
  logic [3:0] r_bcaddr;

  typedef struct {
    logic [1:0] cmd;
    logic [3:0] addr;
    logic [7:0] wd;
    bit         abort;
    logic [7:0] sw;
    int         exp_lat;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl [9];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Reference: memory as a plain array, results from the command rules.
  task automatic modelTxn(input logic [1:0] cmd, input logic [3:0] addr, input logic [7:0] wd,
                          input bit abort, input logic [7:0] sw,
                          output int lat, output logic [7:0] data, output logic [2:0] bc);
    bc = (cmd == 2'd0) ? 3'b001 : (cmd == 2'd1) ? 3'b010 : (cmd == 2'd2) ? 3'b100 : 3'b000;
    if (cmd == 2'd3) begin
      model_mem[addr] = wd;
      lat = 2;
      data = 8'h00;
    end else if (cmd == 2'd2) begin
      lat = 2;
      data = 8'h00;
    end else if (abort) begin
      model_mem[addr] = sw;
      lat = 2;
      data = sw;
    end else begin
      lat = 2 + MEM_LAT;
      data = model_mem[addr];
    end
  endtask

  // Drives one transaction and records what the responder did, cycle by cycle.
  task automatic applyStimulus(input logic [1:0] cmd, input logic [3:0] addr, input logic [7:0] wd,
                               input bit abort, input logic [7:0] sw, input bit hold);
    r_wait = 0; r_lat = -1; r_lat0 = -1; r_data = 8'h00; r_data0 = 8'h00;
    n_rd = 0; n_wr = 0; n_inv = 0; r_bcaddr = 4'h0; r_addr_bad = 0; r_ready_low = 0;
    @(negedge clk);
    req_valid = 1'b1; req_cmd = cmd; req_addr = addr; req_wdata = wd; snoop_abort = 1'b0;
    while (!req_ready && r_wait < 40) begin
      @(negedge clk);
      r_wait++;
    end
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (!hold) begin
        req_valid = 1'b0;
        req_cmd   = 2'($urandom);
        req_addr  = 4'($urandom);
        req_wdata = 8'($urandom);
      end
      if (!req_ready) r_ready_low++;
      if (bus_read_miss || bus_write_miss || bus_invalidate) begin
        n_rd  += int'(bus_read_miss);
        n_wr  += int'(bus_write_miss);
        n_inv += int'(bus_invalidate);
        r_bcaddr = bus_addr;
        snoop_abort = abort;
        snoop_wdata = sw;
      end else begin
        if (bus_addr != 4'h0) r_addr_bad++;
        snoop_abort = 1'($urandom);
        snoop_wdata = 8'($urandom);
      end
      if (resp_valid0 && r_lat0 < 0) begin
        r_lat0 = cyc;
        r_data0 = resp_data0;
      end
      if (resp_valid) begin
        r_lat = cyc;
        r_data = resp_data;
        break;
      end
    end
    snoop_abort = 1'b0;
  endtask

  task automatic checkTxn(input string tag, input int exp_lat, input logic [7:0] exp_data,
                          input logic [2:0] bc, input logic [3:0] addr);
    checkOutput({tag, " accepted"}, int'(r_wait < 40), 1);
    checkOutput({tag, " latency"}, r_lat, exp_lat);
    checkOutput({tag, " resp_data"}, r_data, exp_data);
    checkOutput({tag, " bus_read_miss pulses"}, n_rd, bc[0]);
    checkOutput({tag, " bus_write_miss pulses"}, n_wr, bc[1]);
    checkOutput({tag, " bus_invalidate pulses"}, n_inv, bc[2]);
    if (bc != 3'b000) checkOutput({tag, " bus_addr"}, r_bcaddr, addr);
    checkOutput({tag, " idle bus_addr nonzero"}, r_addr_bad, 0);
  endtask

  initial begin
    int         e_lat;
    logic [7:0] e_data;
    logic [2:0] e_bc;
    int         seen;
    logic [1:0] c;
    logic [3:0] a;
    logic [7:0] w, s;
    bit         ab;

    tbl[0] = '{2'd3, 4'd5,  8'hA7, 1'b0, 8'h00, 2,           8'h00};
    tbl[1] = '{2'd0, 4'd5,  8'h00, 1'b0, 8'h00, 2 + MEM_LAT, 8'hA7};
    tbl[2] = '{2'd1, 4'd5,  8'h00, 1'b1, 8'h3C, 2,           8'h3C};
    tbl[3] = '{2'd0, 4'd5,  8'h00, 1'b0, 8'h00, 2 + MEM_LAT, 8'h3C};
    tbl[4] = '{2'd2, 4'd2,  8'h00, 1'b1, 8'hFF, 2,           8'h00};
    tbl[5] = '{2'd0, 4'd2,  8'h00, 1'b0, 8'h00, 2 + MEM_LAT, 8'h12};
    tbl[6] = '{2'd1, 4'd7,  8'h00, 1'b0, 8'h00, 2 + MEM_LAT, 8'h17};
    tbl[7] = '{2'd0, 4'd15, 8'h00, 1'b1, 8'h55, 2,           8'h55};
    tbl[8] = '{2'd0, 4'd15, 8'h00, 1'b0, 8'h00, 2 + MEM_LAT, 8'h55};

    rst_n = 1'b0; req_valid = 1'b0; req_cmd = 2'd0; req_addr = 4'd0; req_wdata = 8'd0;
    snoop_abort = 1'b0; snoop_wdata = 8'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset req_ready", req_ready, 1);
    checkOutput("reset resp_valid", resp_valid, 0);
    checkOutput("reset resp_data", resp_data, 0);
    checkOutput("reset bus lines", {bus_read_miss, bus_write_miss, bus_invalidate}, 0);
    checkOutput("reset bus_addr", bus_addr, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      w = 8'(8'h10 + i);
      applyStimulus(2'd3, 4'(i), w, 1'b0, 8'h00, 1'b0);
      modelTxn(2'd3, 4'(i), w, 1'b0, 8'h00, e_lat, e_data, e_bc);
      checkTxn($sformatf("fill%0d", i), e_lat, e_data, e_bc, 4'(i));
    end

    for (int i = 0; i < 9; i++) begin
      applyStimulus(tbl[i].cmd, tbl[i].addr, tbl[i].wd, tbl[i].abort, tbl[i].sw, 1'b0);
      modelTxn(tbl[i].cmd, tbl[i].addr, tbl[i].wd, tbl[i].abort, tbl[i].sw, e_lat, e_data, e_bc);
      checkTxn($sformatf("vec%0d", i), tbl[i].exp_lat, tbl[i].exp_data, e_bc, tbl[i].addr);
    end

    // req_valid held high through a read: next request transfers right after RESP.
    applyStimulus(2'd0, 4'd3, 8'h00, 1'b0, 8'h00, 1'b1);
    modelTxn(2'd0, 4'd3, 8'h00, 1'b0, 8'h00, e_lat, e_data, e_bc);
    checkTxn("hold first", e_lat, e_data, e_bc, 4'd3);
    checkOutput("hold ready low cycles", r_ready_low, 2 + MEM_LAT);
    applyStimulus(2'd1, 4'd4, 8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("hold second wait", r_wait, 0);
    modelTxn(2'd1, 4'd4, 8'h00, 1'b0, 8'h00, e_lat, e_data, e_bc);
    checkTxn("hold second", e_lat, e_data, e_bc, 4'd4);

    for (int i = 0; i < 40; i++) begin
      c  = 2'($urandom_range(0, 3));
      a  = 4'($urandom);
      w  = 8'($urandom);
      s  = 8'($urandom);
      ab = 1'($urandom_range(0, 1));
      applyStimulus(c, a, w, ab, s, 1'b0);
      modelTxn(c, a, w, ab, s, e_lat, e_data, e_bc);
      checkTxn($sformatf("rand%0d", i), e_lat, e_data, e_bc, a);
    end

    // Reset in the middle of a memory wait drops the transaction silently.
    @(negedge clk);
    req_valid = 1'b1; req_cmd = 2'd0; req_addr = 4'd1; snoop_abort = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midwait reset resp_valid", resp_valid, 0);
    checkOutput("midwait reset resp_data", resp_data, 0);
    checkOutput("midwait reset bus lines", {bus_read_miss, bus_write_miss, bus_invalidate}, 0);
    checkOutput("midwait reset bus_addr", bus_addr, 0);
    checkOutput("midwait reset req_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    checkOutput("midwait dropped response", seen, 0);
    checkOutput("midwait ready after release", req_ready, 1);

    applyStimulus(2'd0, 4'd1, 8'h00, 1'b0, 8'h00, 1'b0);
    modelTxn(2'd0, 4'd1, 8'h00, 1'b0, 8'h00, e_lat, e_data, e_bc);
    checkTxn("post reset read", e_lat, e_data, e_bc, 4'd1);

    // Zero-latency instance: read miss without abort responds two cycles after transfer.
    applyStimulus(2'd3, 4'd9, 8'h6E, 1'b0, 8'h00, 1'b0);
    modelTxn(2'd3, 4'd9, 8'h6E, 1'b0, 8'h00, e_lat, e_data, e_bc);
    checkTxn("lat0 wb", e_lat, e_data, e_bc, 4'd9);
    checkOutput("lat0 wb latency", r_lat0, 2);
    applyStimulus(2'd0, 4'd9, 8'h00, 1'b0, 8'h00, 1'b0);
    modelTxn(2'd0, 4'd9, 8'h00, 1'b0, 8'h00, e_lat, e_data, e_bc);
    checkTxn("lat0 main read", e_lat, e_data, e_bc, 4'd9);
    checkOutput("lat0 read latency", r_lat0, 2);
    checkOutput("lat0 read data", r_data0, 8'h6E);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
